// File: rtl/x87_pkg.sv
// Shared types for the x87 issue queue: command/result payloads, FSM states, field widths.
package x87_pkg;

    localparam int unsigned X87_OP_W       = 8;
    localparam int unsigned X87_STEP_W     = 4;
    localparam int unsigned X87_MEM32_W    = 32;
    localparam int unsigned X87_MEM64_W    = 64;
    localparam int unsigned X87_WB_KIND_W  = 3;
    localparam int unsigned X87_WB_VALUE_W = 16;
    localparam int unsigned X87_MS_SIZE_W  = 2;

    typedef struct packed {
        logic [X87_OP_W-1:0]    op1;
        logic [X87_OP_W-1:0]    op2;
        logic                   op2_valid;
        logic [X87_STEP_W-1:0]  step;
        logic [X87_MEM32_W-1:0] mem32;
        logic [X87_MEM64_W-1:0] mem64;
    } x87_cmd_t;

    typedef struct packed {
        logic                      wb_valid;
        logic [X87_WB_KIND_W-1:0]  wb_kind;
        logic [X87_WB_VALUE_W-1:0] wb_value;
        logic                      ms_valid;
        logic [X87_MS_SIZE_W-1:0]  ms_size;
        logic [X87_MEM64_W-1:0]    ms_data64;
    } x87_res_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2
    } x87_state_e;

endpackage

// File: rtl/x87_issue_queue_if.sv
// Command push, exec issue/completion and result handshake bundle of the x87 issue queue.
interface x87_issue_queue_if
    import x87_pkg::*;
#(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned STEP_W = 4
);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic                      flush;
    logic                      in_valid;
    logic                      in_ready;
    logic [X87_OP_W-1:0]       in_op1;
    logic [X87_OP_W-1:0]       in_op2;
    logic                      in_op2_valid;
    logic [STEP_W-1:0]         in_step;
    logic [X87_MEM32_W-1:0]    in_mem32;
    logic [X87_MEM64_W-1:0]    in_mem64;

    logic                      ex_start;
    logic [X87_OP_W-1:0]       ex_op1;
    logic [X87_OP_W-1:0]       ex_op2;
    logic                      ex_op2_valid;
    logic [STEP_W-1:0]         ex_step;
    logic [X87_MEM32_W-1:0]    ex_mem32;
    logic [X87_MEM64_W-1:0]    ex_mem64;

    logic                      ex_done;
    logic                      ex_wb_valid;
    logic [X87_WB_KIND_W-1:0]  ex_wb_kind;
    logic [X87_WB_VALUE_W-1:0] ex_wb_value;
    logic                      ex_ms_valid;
    logic [X87_MS_SIZE_W-1:0]  ex_ms_size;
    logic [X87_MEM64_W-1:0]    ex_ms_data64;

    logic                      res_valid;
    logic                      res_ready;
    logic                      res_wb_valid;
    logic [X87_WB_KIND_W-1:0]  res_wb_kind;
    logic [X87_WB_VALUE_W-1:0] res_wb_value;
    logic                      res_ms_valid;
    logic [X87_MS_SIZE_W-1:0]  res_ms_size;
    logic [X87_MEM64_W-1:0]    res_ms_data64;

    logic [CNT_W-1:0]          count;
    logic                      busy;
    logic                      err;

    // The issue queue itself
    modport slave (
        input  flush, in_valid, in_op1, in_op2, in_op2_valid, in_step, in_mem32, in_mem64,
        input  ex_done, ex_wb_valid, ex_wb_kind, ex_wb_value, ex_ms_valid, ex_ms_size, ex_ms_data64,
        input  res_ready,
        output in_ready,
        output ex_start, ex_op1, ex_op2, ex_op2_valid, ex_step, ex_mem32, ex_mem64,
        output res_valid, res_wb_valid, res_wb_kind, res_wb_value, res_ms_valid, res_ms_size, res_ms_data64,
        output count, busy, err
    );

    // Sequencer / exec / core side
    modport master (
        output flush, in_valid, in_op1, in_op2, in_op2_valid, in_step, in_mem32, in_mem64,
        output ex_done, ex_wb_valid, ex_wb_kind, ex_wb_value, ex_ms_valid, ex_ms_size, ex_ms_data64,
        output res_ready,
        input  in_ready,
        input  ex_start, ex_op1, ex_op2, ex_op2_valid, ex_step, ex_mem32, ex_mem64,
        input  res_valid, res_wb_valid, res_wb_kind, res_wb_value, res_ms_valid, res_ms_size, res_ms_data64,
        input  count, busy, err
    );

endinterface

// File: rtl/x87_cmd_fifo.sv
// DEPTH-entry command FIFO with flush; head is read straight from the register array.
module x87_cmd_fifo
    import x87_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   push,
    input  x87_cmd_t               push_data,
    input  logic                   pop,
    output x87_cmd_t               head,
    output logic [$clog2(DEPTH):0] count
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    x87_cmd_t         mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    // No pop credit for a push when full; flush overrides both.
    assign push_ok = push & (count < CNT_W'(DEPTH)) & ~flush;
    assign pop_ok  = pop & (count != '0) & ~flush;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/x87_issue_queue.sv
// Buffered x87 command issue with one outstanding command and a held result handshake.
// Optional X87_ISSUE_BYPASS_EN: a push into an empty idle queue is issued at the push edge.
module x87_issue_queue
    import x87_pkg::*;
#(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned STEP_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    x87_issue_queue_if.slave   bus
);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    x87_state_e       state_q, state_d;
    x87_cmd_t         ex_cmd_q, ex_cmd_d;
    x87_res_t         res_q, res_d;
    logic             ex_start_q, ex_start_d;
    logic             res_valid_q, res_valid_d;
    logic             err_q, err_d;

    x87_cmd_t         in_cmd_c;
    x87_cmd_t         head_c;
    x87_res_t         done_res_c;
    logic             in_ready_c;
    logic             push_c;
    logic             bypass_c;
    logic             pop_c;
    logic [CNT_W-1:0] count_c;

    assign in_cmd_c = '{
        op1:       bus.in_op1,
        op2:       bus.in_op2,
        op2_valid: bus.in_op2_valid,
        step:      X87_STEP_W'(bus.in_step),
        mem32:     bus.in_mem32,
        mem64:     bus.in_mem64
    };

    assign done_res_c = '{
        wb_valid:  bus.ex_wb_valid,
        wb_kind:   bus.ex_wb_kind,
        wb_value:  bus.ex_wb_value,
        ms_valid:  bus.ex_ms_valid,
        ms_size:   bus.ex_ms_size,
        ms_data64: bus.ex_ms_data64
    };

    assign in_ready_c = rst_n & (count_c < CNT_W'(DEPTH)) & ~bus.flush;
    assign push_c     = bus.in_valid & in_ready_c;

`ifdef X87_ISSUE_BYPASS_EN
    assign bypass_c = (state_q == ST_IDLE) & (count_c == '0) & ~res_valid_q & push_c;
`else
    assign bypass_c = 1'b0;
`endif

    x87_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (bus.flush),
        .push      (push_c & ~bypass_c),
        .push_data (in_cmd_c),
        .pop       (pop_c),
        .head      (head_c),
        .count     (count_c)
    );

    // Issue FSM: a flush in the same cycle suppresses popping from the queue.
    always_comb begin
        state_d     = state_q;
        ex_cmd_d    = ex_cmd_q;
        res_d       = res_q;
        ex_start_d  = 1'b0;
        res_valid_d = res_valid_q;
        err_d       = err_q;
        pop_c       = 1'b0;

        if (bus.ex_done && (state_q != ST_WAIT)) begin
            err_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (bypass_c) begin
                    ex_cmd_d   = in_cmd_c;
                    ex_start_d = 1'b1;
                    state_d    = ST_WAIT;
                end else if ((count_c != '0) && !res_valid_q && !bus.flush) begin
                    pop_c      = 1'b1;
                    ex_cmd_d   = head_c;
                    ex_start_d = 1'b1;
                    state_d    = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (bus.ex_done) begin
                    res_d       = done_res_c;
                    res_valid_d = 1'b1;
                    state_d     = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (bus.res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                    if ((count_c != '0) && !bus.flush) begin
                        pop_c      = 1'b1;
                        ex_cmd_d   = head_c;
                        ex_start_d = 1'b1;
                        state_d    = ST_WAIT;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            ex_cmd_q    <= '0;
            res_q       <= '0;
            ex_start_q  <= 1'b0;
            res_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            ex_cmd_q    <= ex_cmd_d;
            res_q       <= res_d;
            ex_start_q  <= ex_start_d;
            res_valid_q <= res_valid_d;
            err_q       <= err_d;
        end
    end

    assign bus.in_ready      = in_ready_c;
    assign bus.ex_start      = ex_start_q;
    assign bus.ex_op1        = ex_cmd_q.op1;
    assign bus.ex_op2        = ex_cmd_q.op2;
    assign bus.ex_op2_valid  = ex_cmd_q.op2_valid;
    assign bus.ex_step       = STEP_W'(ex_cmd_q.step);
    assign bus.ex_mem32      = ex_cmd_q.mem32;
    assign bus.ex_mem64      = ex_cmd_q.mem64;
    assign bus.res_valid     = res_valid_q;
    assign bus.res_wb_valid  = res_q.wb_valid;
    assign bus.res_wb_kind   = res_q.wb_kind;
    assign bus.res_wb_value  = res_q.wb_value;
    assign bus.res_ms_valid  = res_q.ms_valid;
    assign bus.res_ms_size   = res_q.ms_size;
    assign bus.res_ms_data64 = res_q.ms_data64;
    assign bus.count         = count_c;
    assign bus.busy          = (state_q != ST_IDLE) | (count_c != '0) | res_valid_q;
    assign bus.err           = err_q;

endmodule
